// File: rtl/trdb_packet_sched.sv
// Trace packet scheduler: in-order request FIFO between the priority stage and the
// packet emitter, with address-difference feedback, drop accounting and a flush/drain FSM.
package trdb_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned KW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'h0,
    F_DIFF_DELTA = 2'h1,
    F_ADDR_ONLY  = 2'h2,
    F_SYNC       = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_UNDEF   = 2'h3
  } trdb_subformat_e;
endpackage

module trdb_packet_sched
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  trdb_format_e            req_format_i,
  input  trdb_subformat_e         req_subformat_i,
  input  logic [KW-1:0]           req_keep_bits_i,
  input  logic [XLEN-1:0]         req_addr_i,
  output logic [XLEN-1:0]         diff_addr_o,
  output logic [XLEN-1:0]         last_addr_o,
  output logic                    pkt_valid_o,
  input  logic                    pkt_ready_i,
  output trdb_format_e            pkt_format_o,
  output trdb_subformat_e         pkt_subformat_o,
  output logic [KW-1:0]           pkt_keep_bits_o,
  output logic [XLEN-1:0]         pkt_addr_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [XLEN-1:0] last_addr_q;
  logic [15:0]     drop_cnt_q;
  logic            overflow_q;

  trdb_format_e    fmt_mem   [DEPTH];
  trdb_subformat_e sub_mem   [DEPTH];
  logic [KW-1:0]   keep_mem  [DEPTH];
  logic [XLEN-1:0] addr_mem  [DEPTH];

  logic full, empty, push, pop, drop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign req_ready_o = (state_q == S_RUN) && !full;
  assign push        = req_valid_i && req_ready_o;
  assign pkt_valid_o = !empty;
  assign pop         = pkt_valid_o && pkt_ready_i;
  // Requests arriving outside RUN are ignored silently; only a full FIFO in RUN drops.
  assign drop        = req_valid_i && (state_q == S_RUN) && full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush_i)  state_d = S_FLUSH;
      S_FLUSH: if (empty)    state_d = S_DONE;
      S_DONE:  if (!flush_i) state_d = S_RUN;
      default:               state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_addr_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= drop;
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + PW'(1);
        last_addr_q <= req_addr_i;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fmt_mem[wr_ptr_q]  <= req_format_i;
      sub_mem[wr_ptr_q]  <= req_subformat_i;
      keep_mem[wr_ptr_q] <= req_keep_bits_i;
      addr_mem[wr_ptr_q] <= req_addr_i;
    end
  end

  assign pkt_format_o    = pkt_valid_o ? fmt_mem[rd_ptr_q]  : F_ADDR_ONLY;
  assign pkt_subformat_o = pkt_valid_o ? sub_mem[rd_ptr_q]  : SF_UNDEF;
  assign pkt_keep_bits_o = pkt_valid_o ? keep_mem[rd_ptr_q] : '0;
  assign pkt_addr_o      = pkt_valid_o ? addr_mem[rd_ptr_q] : '0;

  assign diff_addr_o  = req_addr_i - last_addr_q;
  assign last_addr_o  = last_addr_q;
  assign flush_done_o = (state_q == S_DONE);
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_trdb_packet_sched.sv
// Bench for trdb_packet_sched: directed scenarios plus random traffic against a queue-based model.
module tb_trdb_packet_sched;
  import trdb_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic                   req_valid_i;
  logic                   req_ready_o;
  trdb_format_e           req_format_i;
  trdb_subformat_e        req_subformat_i;
  logic [KW-1:0]          req_keep_bits_i;
  logic [XLEN-1:0]        req_addr_i;
  logic [XLEN-1:0]        diff_addr_o;
  logic [XLEN-1:0]        last_addr_o;
  logic                   pkt_valid_o;
  logic                   pkt_ready_i;
  trdb_format_e           pkt_format_o;
  trdb_subformat_e        pkt_subformat_o;
  logic [KW-1:0]          pkt_keep_bits_o;
  logic [XLEN-1:0]        pkt_addr_o;
  logic                   flush_i;
  logic                   flush_done_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   overflow_o;
  logic [15:0]            drop_cnt_o;

  trdb_packet_sched #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_format_i    (req_format_i),
    .req_subformat_i (req_subformat_i),
    .req_keep_bits_i (req_keep_bits_i),
    .req_addr_i      (req_addr_i),
    .diff_addr_o     (diff_addr_o),
    .last_addr_o     (last_addr_o),
    .pkt_valid_o     (pkt_valid_o),
    .pkt_ready_i     (pkt_ready_i),
    .pkt_format_o    (pkt_format_o),
    .pkt_subformat_o (pkt_subformat_o),
    .pkt_keep_bits_o (pkt_keep_bits_o),
    .pkt_addr_o      (pkt_addr_o),
    .flush_i         (flush_i),
    .flush_done_o    (flush_done_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    trdb_format_e    f;
    trdb_subformat_e s;
    logic [KW-1:0]   k;
    logic [XLEN-1:0] a;
  } ent_t;

  typedef enum {M_RUN, M_FLUSH, M_DONE} mst_e;

  ent_t        q[$];
  mst_e        mstate = M_RUN;
  logic [31:0] m_last = '0;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  bit          do_check = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("req_ready", req_ready_o, (mstate == M_RUN) && (n < DEPTH));
    chk("pkt_valid", pkt_valid_o, n != 0);
    chk("pkt_format", pkt_format_o, (n != 0) ? q[0].f : F_ADDR_ONLY);
    chk("pkt_subformat", pkt_subformat_o, (n != 0) ? q[0].s : SF_UNDEF);
    chk("pkt_keep_bits", pkt_keep_bits_o, (n != 0) ? q[0].k : '0);
    chk("pkt_addr", pkt_addr_o, (n != 0) ? q[0].a : '0);
    chk("level", level_o, n);
    chk("last_addr", last_addr_o, m_last);
    chk("diff_addr", diff_addr_o, req_addr_i - m_last);
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("overflow", overflow_o, m_ovf);
    chk("flush_done", flush_done_o, mstate == M_DONE);
  endtask

  task automatic model_update();
    int   n = q.size();
    bit   push, pop, drop;
    ent_t e;
    if (!rst_ni) begin
      q.delete();
      mstate = M_RUN;
      m_last = '0;
      m_drop = 0;
      m_ovf  = 1'b0;
      return;
    end
    push  = req_valid_i && (mstate == M_RUN) && (n < DEPTH);
    drop  = req_valid_i && (mstate == M_RUN) && (n == DEPTH);
    pop   = (n != 0) && pkt_ready_i;
    m_ovf = drop;
    if (drop && m_drop < 65535) m_drop++;
    case (mstate)
      M_RUN:   if (flush_i)  mstate = M_FLUSH;
      M_FLUSH: if (n == 0)   mstate = M_DONE;
      M_DONE:  if (!flush_i) mstate = M_RUN;
      default: mstate = M_RUN;
    endcase
    if (pop) void'(q.pop_front());
    if (push) begin
      e.f = req_format_i;
      e.s = req_subformat_i;
      e.k = req_keep_bits_i;
      e.a = req_addr_i;
      q.push_back(e);
      m_last = req_addr_i;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (do_check) check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] addr);
    req_valid_i     = v;
    req_addr_i      = addr;
    req_format_i    = trdb_format_e'($urandom_range(0, 3));
    req_subformat_i = trdb_subformat_e'($urandom_range(0, 3));
    req_keep_bits_i = KW'($urandom_range(0, 32));
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; pkt_ready_i = 1'b0;
    set_req(1'b0, 32'h0);
    @(posedge clk); #1;

    // reset: first cycle unchecked (outputs not yet defined)
    do_check = 1'b0;
    cycle();
    rst_ni = 1'b1;
    do_check = 1'b1;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_pkt_valid", pkt_valid_o, 1'b0);
    chk("rst_flush_done", flush_done_o, 1'b0);
    cycle();

    // in-order emission with ready consumer
    pkt_ready_i = 1'b1;
    set_req(1'b1, 32'h100); cycle();
    chk("lat_first", pkt_addr_o, 32'h100);
    set_req(1'b1, 32'h104); cycle();
    chk("lat_second", pkt_addr_o, 32'h104);
    set_req(1'b1, 32'h200); cycle();
    chk("lat_third", pkt_addr_o, 32'h200);
    set_req(1'b0, 32'h210); #1;
    chk("last_addr_200", last_addr_o, 32'h200);
    chk("diff_addr_10", diff_addr_o, 32'h10);
    cycle();

    // fill with stalled consumer, 5th request dropped
    pkt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, $urandom);
      cycle();
    end
    set_req(1'b0, 32'h0); #1;
    chk("full_level", level_o, 4);
    chk("full_ready", req_ready_o, 1'b0);
    chk("drop_one", drop_cnt_o, 16'd1);
    chk("ovf_pulse", overflow_o, 1'b1);
    cycle();
    chk("ovf_clear", overflow_o, 1'b0);

    // full with push and pop together: pop only, drop counted
    set_req(1'b1, 32'hdead0000); pkt_ready_i = 1'b1; cycle();
    set_req(1'b0, 32'h0); pkt_ready_i = 1'b0; #1;
    chk("pp_level", level_o, 3);
    chk("pp_drop", drop_cnt_o, 16'd2);
    chk("pp_ready", req_ready_o, 1'b1);
    cycle();

    // flush drains 3 entries, then returns to RUN
    flush_i = 1'b1; pkt_ready_i = 1'b1; cycle();
    chk("flush_ready", req_ready_o, 1'b0);
    set_req(1'b1, 32'hbeef);
    for (int i = 0; i < 20 && !flush_done_o; i++) cycle();
    chk("flush_done_reached", flush_done_o, 1'b1);
    chk("flush_empty", level_o, 0);
    chk("flush_no_drop", drop_cnt_o, 16'd2);
    set_req(1'b0, 32'h0);
    flush_i = 1'b0; cycle();
    chk("unflush_ready", req_ready_o, 1'b1);
    chk("unflush_done", flush_done_o, 1'b0);

    // negative difference wraps
    set_req(1'b1, 32'h10); cycle();
    set_req(1'b0, 32'h8); #1;
    chk("diff_wrap", diff_addr_o, 32'hFFFFFFF8);
    cycle();

    // reset mid-flush with entries queued
    pkt_ready_i = 1'b0;
    set_req(1'b1, $urandom); cycle();
    set_req(1'b1, $urandom); cycle();
    set_req(1'b0, 32'h0); flush_i = 1'b1; cycle(); cycle();
    chk("mf_level", level_o, 2);
    chk("mf_done", flush_done_o, 1'b0);
    rst_ni = 1'b0; cycle();
    rst_ni = 1'b1; flush_i = 1'b0; #1;
    chk("mr_level", level_o, 0);
    chk("mr_last", last_addr_o, 0);
    chk("mr_drop", drop_cnt_o, 0);
    chk("mr_ready", req_ready_o, 1'b1);
    cycle();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      set_req(1'($urandom_range(0, 1)), $urandom);
      pkt_ready_i = 1'($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) flush_i = ~flush_i;
      cycle();
    end

    // drop counter saturation
    set_req(1'b0, 32'h0); flush_i = 1'b0; pkt_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    pkt_ready_i = 1'b0;
    set_req(1'b1, 32'h1234);
    do_check = 1'b0;
    for (int i = 0; i < 65540; i++) cycle();
    do_check = 1'b1;
    cycle();
    chk("drop_sat", drop_cnt_o, 16'hFFFF);
    chk("sat_ovf", overflow_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trdb_packet_sched.md
TRDB_PACKET_SCHED -- requirements
Module: trdb_packet_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending packet requests buffered; power of two, >= 2.
REQ-002 SHALL take XLEN, trdb_format_e and trdb_subformat_e from trdb_pkg (XLEN = 32); KW = $clog2(XLEN)+1 = 6.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_valid_i, input, 1, packet request from priority stage.
REQ-006 SHALL have port req_ready_o, output, 1, request accepted when high with req_valid_i.
REQ-007 SHALL have ports req_format_i (trdb_format_e), req_subformat_i (trdb_subformat_e), req_keep_bits_i (KW), req_addr_i (XLEN), all inputs, request payload.
REQ-008 SHALL have port diff_addr_o, output, XLEN, req_addr_i minus last_addr_o, fed back to the priority stage.
REQ-009 SHALL have port last_addr_o, output, XLEN, address of the most recently accepted request.
REQ-010 SHALL have ports pkt_valid_o (output, 1) and pkt_ready_i (input, 1), handshake toward packet emitter.
REQ-011 SHALL have ports pkt_format_o, pkt_subformat_o, pkt_keep_bits_o (KW), pkt_addr_o (XLEN), all outputs, head-entry payload.
REQ-012 SHALL have port flush_i, input, 1, drain request (e.g. trace disable).
REQ-013 SHALL have port flush_done_o, output, 1, high while in DONE state.
REQ-014 SHALL have ports level_o ($clog2(DEPTH)+1, output, entries held), overflow_o (1, output, drop pulse), drop_cnt_o (16, output, dropped requests).

Function
REQ-015 SHALL store accepted requests in an in-order FIFO of DEPTH entries; payload emitted unmodified.
REQ-016 SHALL drive req_ready_o = (state == RUN) && (level_o < DEPTH); no bypass, so a pop in the same cycle does not make a full FIFO ready.
REQ-017 SHALL push on req_valid_i && req_ready_o; the entry is visible on pkt_* the following cycle at the earliest (1-cycle latency).
REQ-018 SHALL drive pkt_valid_o = (level_o != 0); pop on pkt_valid_o && pkt_ready_i; pkt_* hold stable while pkt_valid_o && !pkt_ready_i.
REQ-019 SHALL drive pkt_format_o = F_ADDR_ONLY, pkt_subformat_o = SF_UNDEF, pkt_keep_bits_o = 0, pkt_addr_o = 0 when pkt_valid_o is low.
REQ-020 SHALL, on simultaneous push and pop, keep level_o unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-021 SHALL load last_addr_o with req_addr_i on every push; no update on drop or when not in RUN.
REQ-022 SHALL compute diff_addr_o = req_addr_i - last_addr_o combinationally, modulo 2^XLEN (wrap, no saturation).
REQ-023 SHALL treat req_valid_i high in RUN with the FIFO full as a drop: payload discarded, drop_cnt_o += 1 saturating at 16'hFFFF, overflow_o high exactly one cycle later for one cycle per dropped request.
REQ-024 SHALL implement FSM states RUN, FLUSH, DONE; RUN -> FLUSH when flush_i = 1; FLUSH -> DONE when level_o == 0 (regardless of flush_i); DONE -> RUN when flush_i = 0.
REQ-025 SHALL in FLUSH and DONE deassert req_ready_o, ignore req_valid_i without counting drops, and keep popping normally.
REQ-026 SHALL, in RUN with flush_i = 1 and FIFO empty, go to FLUSH, then DONE the next cycle (flush_done_o 2 cycles after flush_i).

Reset
REQ-027 SHALL, while rst_ni = 0 at a clock edge, clear FIFO (level_o = 0, pointers 0), last_addr_o = 0, drop_cnt_o = 0, overflow_o = 0, state = RUN; pending entries are lost.
REQ-028 SHALL, one cycle after reset, output req_ready_o = 1, pkt_valid_o = 0, flush_done_o = 0, pkt_* at REQ-019 defaults.

Verification
REQ-029 SHALL cover: push addr 0x100, 0x104, 0x200 with pkt_ready_i = 1 -> emitted in order, each 1 cycle after push; last_addr_o = 0x200; diff_addr_o = 0x10 for req_addr_i = 0x210.
REQ-030 SHALL cover: pkt_ready_i = 0, 5 pushes into DEPTH = 4 -> first 4 accepted, level_o = 4, req_ready_o = 0, 5th dropped, drop_cnt_o = 1, overflow_o one-cycle pulse.
REQ-031 SHALL cover: full FIFO, req_valid_i and pkt_ready_i both high -> pop only, level_o = 3, drop counted, next cycle req_ready_o = 1.
REQ-032 SHALL cover: 3 entries queued, flush_i = 1 with pkt_ready_i = 1 -> req_ready_o = 0, 3 pops, flush_done_o = 1 after empty; flush_i = 0 -> RUN, req_ready_o = 1.
REQ-033 SHALL cover: last_addr_o = 0x10, req_addr_i = 0x8 -> diff_addr_o = 0xFFFFFFF8; drop_cnt_o preset to 0xFFFF plus one drop -> stays 0xFFFF.
REQ-034 SHALL cover: rst_ni = 0 for one cycle with 2 entries queued mid-flush -> next cycle level_o = 0, state RUN, last_addr_o = 0, drop_cnt_o = 0.
